// File: rtl/veririsc_controller.sv
// Eight-phase instruction sequencer for the 8-bit VeriRISC core.
// Decodes opcode, zero flag and halt state into all datapath control strobes.
module veririsc_controller #(
  parameter int opcode_width = 3,
  parameter int phase_width  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [opcode_width-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    wr,
  output logic                    data_e,
  output logic                    halt,
  output logic [phase_width-1:0]  phase
);

  typedef enum logic [phase_width-1:0] {
    INST_ADDR  = phase_width'(0),
    INST_FETCH = phase_width'(1),
    INST_LOAD  = phase_width'(2),
    IDLE       = phase_width'(3),
    OP_ADDR    = phase_width'(4),
    OP_FETCH   = phase_width'(5),
    ALU_OP     = phase_width'(6),
    STORE      = phase_width'(7)
  } phase_e;

  localparam logic [opcode_width-1:0] OP_HLT = opcode_width'(0);
  localparam logic [opcode_width-1:0] OP_SKZ = opcode_width'(1);
  localparam logic [opcode_width-1:0] OP_ADD = opcode_width'(2);
  localparam logic [opcode_width-1:0] OP_AND = opcode_width'(3);
  localparam logic [opcode_width-1:0] OP_XOR = opcode_width'(4);
  localparam logic [opcode_width-1:0] OP_LDA = opcode_width'(5);
  localparam logic [opcode_width-1:0] OP_STO = opcode_width'(6);
  localparam logic [opcode_width-1:0] OP_JMP = opcode_width'(7);

  phase_e r_phase;
  phase_e w_phase_next;
  logic   r_halt;
  logic   w_halt_next;

  logic w_is_hlt;
  logic w_is_skz;
  logic w_is_sto;
  logic w_is_jmp;
  logic w_is_aluop;

  assign w_is_hlt   = (opcode == OP_HLT);
  assign w_is_skz   = (opcode == OP_SKZ);
  assign w_is_sto   = (opcode == OP_STO);
  assign w_is_jmp   = (opcode == OP_JMP);
  assign w_is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= INST_ADDR;
      r_halt  <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
      r_halt  <= w_halt_next;
    end
  end

  // A halt entry parks the sequencer in OP_ADDR instead of advancing.
  always_comb begin
    w_phase_next = r_phase;
    w_halt_next  = r_halt;
    if (!r_halt && en) begin
      if (r_phase == OP_ADDR && w_is_hlt) begin
        w_halt_next = 1'b1;
      end else begin
        w_phase_next = phase_e'(r_phase + phase_width'(1));
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // for strobes that a given phase leaves unassigned.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    unique case (r_phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = !w_is_hlt && !r_halt;
      end
      OP_FETCH: begin
        rd = w_is_aluop;
      end
      ALU_OP: begin
        rd     = w_is_aluop;
        inc_pc = w_is_skz && zero;
        ld_pc  = w_is_jmp;
        data_e = w_is_sto;
      end
      STORE: begin
        rd     = w_is_aluop;
        ld_ac  = w_is_aluop;
        ld_pc  = w_is_jmp;
        wr     = w_is_sto;
        data_e = w_is_sto;
      end
      default: ;
    endcase
  end

  assign halt  = r_halt || (r_phase == OP_ADDR && w_is_hlt);
  assign phase = r_phase;

endmodule

// File: tb/tb_veririsc_controller.sv
// Scoreboard bench for veririsc_controller: a reference model pushes expected
// strobes each cycle, and the live DUT outputs are popped against them.
module tb_veririsc_controller;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  veririsc_controller #(.opcode_width(3), .phase_width(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  m_phase;
  logic        m_halt;

  // Packing order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt phase[2:0]
  function automatic logic [11:0] model_vec(input logic [2:0] op, input logic z);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    s = 0; r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; de = 0;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    case (m_phase)
      3'd0: s = 1;
      3'd1: begin s = 1; r = 1; end
      3'd2, 3'd3: begin s = 1; r = 1; li = 1; end
      3'd4: ip = (op != HLT) && !m_halt;
      3'd5: r = alu;
      3'd6: begin r = alu; ip = (op == SKZ) && z; lp = (op == JMP); de = (op == STO); end
      default: begin
        r = alu; la = alu; lp = (op == JMP); w = (op == STO); de = (op == STO);
      end
    endcase
    h = m_halt || (m_phase == 3'd4 && op == HLT);
    return {s, r, li, ip, lp, la, w, de, h, m_phase};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
  endfunction

  task automatic sb_push(input string tag);
    sb_entry_t e;
    e.tag = $sformatf("%s_p%0d", tag, m_phase);
    e.exp = model_vec(opcode, zero);
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_compare();
    sb_entry_t e;
    logic [11:0] act;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: got output with no expected entry");
    end else begin
      e = sb_q.pop_front();
      act = dut_vec();
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %b exp %b (sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt phase)",
                 e.tag, act, e.exp);
      end
    end
  endtask

  // Called just after a falling edge: drive, check, then step the model on the rising edge.
  task automatic apply(input string tag, input logic e_in, input logic [2:0] op, input logic z);
    en = e_in; opcode = op; zero = z;
    #1;
    sb_push(tag);
    sb_pop_compare();
    @(posedge clk);
    if (rst_n && !m_halt && e_in) begin
      if (m_phase == 3'd4 && op == HLT) m_halt = 1'b1;
      else m_phase = m_phase + 3'd1;
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) apply(tag, 1'b1, op, z);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; opcode = ADD; zero = 1'b0;
    m_phase = 3'd0; m_halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    sb_push("reset");
    sb_pop_compare();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_instr("add", ADD, 1'b0);
    apply("add_wrap", 1'b1, ADD, 1'b0);
    for (int i = 1; i < 8; i++) apply("add_fill", 1'b1, ADD, 1'b0);
  endtask

  task automatic test_sto();
    run_instr("sto", STO, 1'b0);
  endtask

  task automatic test_skz();
    run_instr("skz_z1", SKZ, 1'b1);
    run_instr("skz_z0", SKZ, 1'b0);
    for (int i = 0; i < 8; i++) apply("skz_tog5", 1'b1, SKZ, (i == 5));
  endtask

  task automatic test_jmp();
    run_instr("jmp", JMP, 1'b0);
  endtask

  task automatic test_hlt();
    for (int i = 0; i < 5; i++) apply("hlt_enter", 1'b1, HLT, 1'b0);
    for (int i = 0; i < 22; i++) apply("hlt_park", (i % 3) != 0, HLT, i[0]);
    rst_n = 1'b0;
    m_phase = 3'd0; m_halt = 1'b0;
    #1;
    sb_push("hlt_reset");
    sb_pop_compare();
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_instr("hlt_resume", ADD, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 7; i++) apply("stall_pre", 1'b1, STO, 1'b0);
    for (int i = 0; i < 3; i++) apply("stall_hold", 1'b0, STO, 1'b0);
    apply("stall_go", 1'b1, STO, 1'b0);
    apply("stall_wrap", 1'b1, STO, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 5; i++) apply("ares_pre", 1'b1, ADD, 1'b0);
    en = 1'b1; opcode = ADD; zero = 1'b0;
    #1;
    sb_push("ares_mid");
    sb_pop_compare();
    #1 rst_n = 1'b0;
    m_phase = 3'd0; m_halt = 1'b0;
    #1;
    sb_push("ares_now");
    sb_pop_compare();
    @(posedge clk);
    @(negedge clk);
    apply("ares_held", 1'b1, ADD, 1'b0);
    rst_n = 1'b1;
    run_instr("ares_after", ADD, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_stall();
    test_async_reset();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending entries exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
